lidar_scan_controller: RTL and testbench
========================================

# lidar_scan_controller

Sequences the LiDAR sensor over the shared UART link. On a scan request, it transmits the stop-scan and start-scan command pairs through the UART transmitter, then enables the LiDAR packet parser. A watchdog restarts the sensor when packets stop arriving. It sits between the UART TX/RX pair and the packet parser and owns the parser's read-enable.

## Interface
Parameters:
- `STOP_GAP_CYCLES`, default 100000: idle cycles between the stop command and the start command, so the sensor drains its output.
- `WATCHDOG_CYCLES`, default 2000000: maximum cycles without a parser packet before a restart.
- `RETRY_LIMIT`, default 3: consecutive failed restarts before the block declares a fault.

Ports:
- `clk_in` input 1: system clock. Single clock domain.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `scan_en_in` input 1: level. 1 requests scanning; 0 requests shutdown.
- `tx_done_in` input 1: one-cycle pulse from the UART transmitter when a byte completes.
- `pkt_valid_in` input 1: one-cycle pulse from the parser (its `new_data`) for each decoded sample.
- `tx_data_out` output 8: command byte to the UART transmitter.
- `tx_start_out` output 1: one-cycle pulse that launches `tx_data_out`.
- `parser_en_out` output 1: drives the parser's read-enable.
- `scanning_out` output 1: high in RUN.
- `fault_out` output 1: high in FAULT.
- `retry_cnt_out` output 4: current consecutive-restart count.

## Operation
- Commands are two bytes, sent header first:
  - stop: 0xA5, 0x65
  - start: 0xA5, 0x60
- States: IDLE, SEND_STOP, STOP_GAP, SEND_START, WAIT_FIRST, RUN, SHUTDOWN, FAULT.
- IDLE to SEND_STOP when `scan_en_in` = 1.
- SEND_STOP: send both stop bytes. After the second `tx_done_in`, go to STOP_GAP.
- STOP_GAP: count `STOP_GAP_CYCLES`, then go to SEND_START.
- SEND_START: send both start bytes. After the second `tx_done_in`, go to WAIT_FIRST.
- WAIT_FIRST: `parser_en_out` = 1 and the watchdog runs. On `pkt_valid_in`, go to RUN and clear `retry_cnt_out`.
- RUN: every `pkt_valid_in` reloads the watchdog.
- Watchdog expiry in WAIT_FIRST or RUN:
  - If `retry_cnt_out` + 1 = `RETRY_LIMIT`, go to FAULT.
  - Otherwise increment `retry_cnt_out` and go to SEND_STOP.
  - `parser_en_out` drops in the same transition.
- `scan_en_in` = 0:
  - In WAIT_FIRST or RUN: go to SHUTDOWN at once, dropping `parser_en_out`.
  - In SEND_STOP or SEND_START with a byte in flight: wait for that byte's `tx_done_in`, then go to SHUTDOWN.
  - In STOP_GAP: go to SHUTDOWN immediately.
- SHUTDOWN sends the stop command, then goes to IDLE and clears `retry_cnt_out`.
- FAULT holds, with `fault_out` = 1, until `scan_en_in` = 0. It then goes to IDLE directly and sends no command.
- `scan_en_in` returning to 1 during SHUTDOWN is ignored until IDLE is reached.

## Timing
- Reset values of all outputs are 0 and the state is IDLE. Reset is asynchronous and may occur mid-byte. No byte is resumed after reset.
- Byte handshake:
  - `tx_start_out` pulses for exactly one cycle.
  - `tx_data_out` is valid in that cycle and held stable until the matching `tx_done_in`.
  - A `tx_done_in` in the same cycle as `tx_start_out` is ignored.
  - The next byte's `tx_start_out` comes exactly one cycle after the previous `tx_done_in`.
- Latency: with `scan_en_in` seen high in IDLE at edge N, `tx_start_out` = 1 with 0xA5 in cycle N+1.
- Watchdog:
  - Counter width is clog2(`WATCHDOG_CYCLES`+1).
  - It loads on WAIT_FIRST/RUN entry and on each `pkt_valid_in`.
  - It expires when it has counted `WATCHDOG_CYCLES` cycles.
  - If `pkt_valid_in` and expiry occur in the same cycle, the packet wins and there is no restart.
- `pkt_valid_in` outside WAIT_FIRST/RUN is ignored.
- `scanning_out`, `fault_out` and `parser_en_out` are registered and change in the cycle after the state transition.
- `retry_cnt_out` saturates at `RETRY_LIMIT`.

## Structure
- Shared package `lidar_pkg` holds:
  - the command byte constants: CMD_HDR = 0xA5, CMD_STOP = 0x65, CMD_START = 0x60
  - the controller state enum
  - the packet header constants shared with the parser
- One sub-module, `lidar_cmd_tx`:
  - Accepts a command code and a go pulse.
  - Emits the two-byte handshake on `tx_start_out`/`tx_data_out`.
  - Returns a one-cycle `cmd_done`.
  - Is used by SEND_STOP, SEND_START and SHUTDOWN.

## Test plan
- Normal start: `scan_en_in`=1; `tx_done_in` 10 cycles after each `tx_start_out`; `STOP_GAP_CYCLES`=50. Bytes A5, 65, a 50-cycle gap, then A5, 60. `parser_en_out` rises. First `pkt_valid_in` gives `scanning_out`=1 and `retry_cnt_out`=0.
- Watchdog restart: `WATCHDOG_CYCLES`=200; in RUN, withhold packets. 200 cycles after the last packet, `parser_en_out` drops, `retry_cnt_out`=1 and A5, 65 is resent.
- Fault: `RETRY_LIMIT`=3 and no packets ever. After the third expiry, `fault_out`=1 with no further `tx_start_out`. `scan_en_in`=0 returns to IDLE with `fault_out`=0.
- Shutdown mid-byte: drop `scan_en_in` while 0x60 is in flight. 0x60 completes, then A5, 65 is sent, then IDLE; 0xA5 is never restarted.
- Same-cycle race: `pkt_valid_in` on the exact expiry cycle keeps RUN with `retry_cnt_out` unchanged.
- Asynchronous reset asserted mid-SEND_START: all outputs are 0 immediately. After release with `scan_en_in`=1, the sequence restarts from A5, 65.

Source files
------------

// File: rtl/lidar_pkg.sv
// Shared definitions for the LiDAR scan controller, its command transmitter
// and the packet parser that sits behind it.
package lidar_pkg;

  localparam logic [7:0] CMD_HDR   = 8'hA5;
  localparam logic [7:0] CMD_STOP  = 8'h65;
  localparam logic [7:0] CMD_START = 8'h60;

  // Response descriptor sync bytes the parser looks for after a start command.
  localparam logic [7:0] RESP_SYNC0    = 8'hA5;
  localparam logic [7:0] RESP_SYNC1    = 8'h5A;
  localparam logic [7:0] RESP_DESC_LEN = 8'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_STOP  = 3'd1,
    ST_STOP_GAP   = 3'd2,
    ST_SEND_START = 3'd3,
    ST_WAIT_FIRST = 3'd4,
    ST_RUN        = 3'd5,
    ST_SHUTDOWN   = 3'd6,
    ST_FAULT      = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HDR  = 2'd1,
    PH_CODE = 2'd2
  } cmd_phase_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
    if (value >= limit) begin
      sat_inc4 = limit;
    end else begin
      sat_inc4 = value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/lidar_cmd_tx.sv
// Two-byte command sender: header 0xA5 then the command code, one UART byte at a
// time, with an optional abort that stops after the byte currently in flight.
module lidar_cmd_tx
  import lidar_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       i_go,
  input  logic [7:0] i_code,
  input  logic       i_abort,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_cmd_done
);

  cmd_phase_e r_phase;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic [7:0] r_code;
  logic       w_accept;
  logic       w_done;

  // A done pulse coinciding with our own start pulse belongs to an older byte.
  assign w_accept   = i_tx_done & ~r_tx_start & (r_phase != PH_IDLE);
  assign w_done     = w_accept & ((r_phase == PH_CODE) | ((r_phase == PH_HDR) & i_abort));
  assign o_cmd_done = w_done;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

  // Byte sequencer: launches the next byte in the cycle after each completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase    <= PH_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_code     <= 8'h00;
    end else if ((w_done || r_phase == PH_IDLE) && i_go) begin
      r_phase    <= PH_HDR;
      r_tx_start <= 1'b1;
      r_tx_data  <= CMD_HDR;
      r_code     <= i_code;
    end else if (w_done) begin
      r_phase    <= PH_IDLE;
      r_tx_start <= 1'b0;
    end else if (w_accept) begin
      r_phase    <= PH_CODE;
      r_tx_start <= 1'b1;
      r_tx_data  <= r_code;
    end else begin
      r_tx_start <= 1'b0;
    end
  end

endmodule

// File: rtl/lidar_scan_controller.sv
// Scan sequencer for the LiDAR: stop/gap/start command handshake, parser enable,
// packet watchdog with bounded restarts and a latched fault state.
module lidar_scan_controller
  import lidar_pkg::*;
#(
  parameter int STOP_GAP_CYCLES = 100000,
  parameter int WATCHDOG_CYCLES = 2000000,
  parameter int RETRY_LIMIT     = 3
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       scan_en_in,
  input  logic       tx_done_in,
  input  logic       pkt_valid_in,
  output logic [7:0] tx_data_out,
  output logic       tx_start_out,
  output logic       parser_en_out,
  output logic       scanning_out,
  output logic       fault_out,
  output logic [3:0] retry_cnt_out
);

  localparam int GAP_W = $clog2(STOP_GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STOP_GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [3:0]       RETRY_LIM = 4'(RETRY_LIMIT);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_next;
  logic             r_scanning;
  logic             r_fault;
  logic             r_parser_en;
  logic             w_go;
  logic [7:0]       w_code;
  logic             w_abort;
  logic             w_cmd_done;
  logic             w_wd_active;
  logic             w_wd_expire;
  logic             w_gap_done;

  assign w_wd_active = (r_state == ST_WAIT_FIRST) | (r_state == ST_RUN);
  assign w_wd_expire = (r_wd_cnt == WD_ONE);
  assign w_gap_done  = (r_gap_cnt == GAP_ONE);

  lidar_cmd_tx u_cmd_tx (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_go       (w_go),
    .i_code     (w_code),
    .i_abort    (w_abort),
    .i_tx_done  (tx_done_in),
    .o_tx_start (tx_start_out),
    .o_tx_data  (tx_data_out),
    .o_cmd_done (w_cmd_done)
  );

  // Next-state, command launch and retry bookkeeping.
  always_comb begin
    w_next       = r_state;
    w_go         = 1'b0;
    w_code       = CMD_STOP;
    w_abort      = 1'b0;
    w_retry_next = r_retry;
    case (r_state)
      ST_IDLE: begin
        if (scan_en_in) begin
          w_next = ST_SEND_STOP;
          w_go   = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SEND_STOP, ST_SEND_START: begin
        w_abort = ~scan_en_in;
        if (w_cmd_done) begin
          if (!scan_en_in) begin
            w_next = ST_SHUTDOWN;
            w_go   = 1'b1;
          end else if (r_state == ST_SEND_STOP) begin
            w_next = ST_STOP_GAP;
          end else begin
            w_next = ST_WAIT_FIRST;
          end
        end else begin
          w_next = r_state;
        end
      end
      ST_STOP_GAP: begin
        if (!scan_en_in) begin
          w_next = ST_SHUTDOWN;
          w_go   = 1'b1;
        end else if (w_gap_done) begin
          w_next = ST_SEND_START;
          w_go   = 1'b1;
          w_code = CMD_START;
        end else begin
          w_next = ST_STOP_GAP;
        end
      end
      ST_WAIT_FIRST, ST_RUN: begin
        // Shutdown beats a packet, and a packet beats an expiry in the same cycle.
        if (!scan_en_in) begin
          w_next = ST_SHUTDOWN;
          w_go   = 1'b1;
        end else if (pkt_valid_in) begin
          w_next       = ST_RUN;
          w_retry_next = 4'd0;
        end else if (w_wd_expire) begin
          if ((r_retry + 4'd1) == RETRY_LIM) begin
            w_next = ST_FAULT;
          end else begin
            w_next       = ST_SEND_STOP;
            w_go         = 1'b1;
            w_retry_next = sat_inc4(r_retry, RETRY_LIM);
          end
        end else begin
          w_next = r_state;
        end
      end
      ST_SHUTDOWN: begin
        if (w_cmd_done) begin
          w_next       = ST_IDLE;
          w_retry_next = 4'd0;
        end else begin
          w_next = ST_SHUTDOWN;
        end
      end
      ST_FAULT: begin
        if (!scan_en_in) begin
          w_next       = ST_IDLE;
          w_retry_next = 4'd0;
        end else begin
          w_next = ST_FAULT;
        end
      end
      default: begin
        w_next       = ST_IDLE;
        w_retry_next = 4'd0;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_scanning  <= 1'b0;
      r_fault     <= 1'b0;
      r_parser_en <= 1'b0;
      r_retry     <= 4'd0;
    end else begin
      r_state     <= w_next;
      r_scanning  <= (w_next == ST_RUN);
      r_fault     <= (w_next == ST_FAULT);
      r_parser_en <= (w_next == ST_WAIT_FIRST) | (w_next == ST_RUN);
      r_retry     <= w_retry_next;
    end
  end

  // Drain gap between stop and start commands.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (r_state != ST_STOP_GAP) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (r_gap_cnt > GAP_ONE) begin
      r_gap_cnt <= r_gap_cnt - GAP_ONE;
    end else begin
      r_gap_cnt <= r_gap_cnt;
    end
  end

  // Packet watchdog: preloaded outside the listening states, reloaded per packet.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wd_cnt <= WD_LOAD;
    end else if (!w_wd_active || pkt_valid_in) begin
      r_wd_cnt <= WD_LOAD;
    end else if (r_wd_cnt > WD_ONE) begin
      r_wd_cnt <= r_wd_cnt - WD_ONE;
    end else begin
      r_wd_cnt <= r_wd_cnt;
    end
  end

  assign scanning_out  = r_scanning;
  assign fault_out     = r_fault;
  assign parser_en_out = r_parser_en;
  assign retry_cnt_out = r_retry;

endmodule

// File: tb/tb_lidar_scan_controller.sv
// Directed bench for lidar_scan_controller with a 10-cycle UART byte responder.
module tb_lidar_scan_controller;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       scan_en_in;
  logic       tx_done_in;
  logic       pkt_valid_in;
  logic [7:0] tx_data_out;
  logic       tx_start_out;
  logic       parser_en_out;
  logic       scanning_out;
  logic       fault_out;
  logic [3:0] retry_cnt_out;

  int n_cmp  = 0;
  int n_fail = 0;

  lidar_scan_controller #(
    .STOP_GAP_CYCLES (50),
    .WATCHDOG_CYCLES (200),
    .RETRY_LIMIT     (3)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .scan_en_in    (scan_en_in),
    .tx_done_in    (tx_done_in),
    .pkt_valid_in  (pkt_valid_in),
    .tx_data_out   (tx_data_out),
    .tx_start_out  (tx_start_out),
    .parser_en_out (parser_en_out),
    .scanning_out  (scanning_out),
    .fault_out     (fault_out),
    .retry_cnt_out (retry_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input logic [7:0] exp, input string tag, output int waited);
    waited = 0;
    while (tx_start_out !== 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    check({tag, "_start"}, 32'(tx_start_out), 32'd1);
    check({tag, "_data"}, 32'(tx_data_out), 32'(exp));
  endtask

  // Completes the byte launched in the current cycle: done 10 cycles after start.
  task automatic finish_byte(input logic [7:0] exp, input string tag);
    tick();
    check({tag, "_pulse1"}, 32'(tx_start_out), 32'd0);
    repeat (8) tick();
    check({tag, "_held"}, 32'(tx_data_out), 32'(exp));
    tx_done_in = 1'b1;
    tick();
    tx_done_in = 1'b0;
  endtask

  task automatic uart_byte(input logic [7:0] exp, input string tag, output int waited);
    wait_start(exp, tag, waited);
    finish_byte(exp, tag);
  endtask

  // Stop command, 50-cycle gap, start command; ends in WAIT_FIRST.
  task automatic full_seq(input string tag);
    int w;
    uart_byte(8'hA5, {tag, "_stop_hdr"}, w);
    uart_byte(8'h65, {tag, "_stop_code"}, w);
    check({tag, "_stop_code_gap"}, 32'(w), 32'd0);
    uart_byte(8'hA5, {tag, "_start_hdr"}, w);
    check({tag, "_drain_gap"}, 32'(w), 32'd50);
    uart_byte(8'h60, {tag, "_start_code"}, w);
    check({tag, "_start_code_gap"}, 32'(w), 32'd0);
    check({tag, "_parser_en"}, 32'(parser_en_out), 32'd1);
    check({tag, "_not_scanning"}, 32'(scanning_out), 32'd0);
  endtask

  initial begin
    int w;
    int seen;
    rst_n_in     = 1'b0;
    scan_en_in   = 1'b0;
    tx_done_in   = 1'b0;
    pkt_valid_in = 1'b0;
    #2;
    check("rst_tx_start", 32'(tx_start_out), 32'd0);
    check("rst_tx_data", 32'(tx_data_out), 32'd0);
    check("rst_parser_en", 32'(parser_en_out), 32'd0);
    check("rst_scanning", 32'(scanning_out), 32'd0);
    check("rst_fault", 32'(fault_out), 32'd0);
    check("rst_retry", 32'(retry_cnt_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    tick();
    check("idle_no_start", 32'(tx_start_out), 32'd0);

    // Normal start: header launched on the first edge that sees scan_en.
    scan_en_in = 1'b1;
    tick();
    check("latency_start", 32'(tx_start_out), 32'd1);
    check("latency_data", 32'(tx_data_out), 32'hA5);
    full_seq("norm");
    repeat (3) tick();
    pkt_valid_in = 1'b1;
    tick();
    pkt_valid_in = 1'b0;
    check("norm_scanning", 32'(scanning_out), 32'd1);
    check("norm_retry", 32'(retry_cnt_out), 32'd0);

    // Packet on the exact expiry cycle keeps RUN.
    repeat (199) tick();
    pkt_valid_in = 1'b1;
    tick();
    pkt_valid_in = 1'b0;
    check("race_scanning", 32'(scanning_out), 32'd1);
    check("race_parser_en", 32'(parser_en_out), 32'd1);
    check("race_no_tx", 32'(tx_start_out), 32'd0);
    check("race_retry", 32'(retry_cnt_out), 32'd0);

    // Watchdog restart 200 cycles after the last packet.
    repeat (199) tick();
    check("wd_pre_parser_en", 32'(parser_en_out), 32'd1);
    check("wd_pre_no_tx", 32'(tx_start_out), 32'd0);
    tick();
    check("wd_parser_en", 32'(parser_en_out), 32'd0);
    check("wd_scanning", 32'(scanning_out), 32'd0);
    check("wd_retry", 32'(retry_cnt_out), 32'd1);
    check("wd_resend_start", 32'(tx_start_out), 32'd1);
    full_seq("wd");
    check("wd_retry_held", 32'(retry_cnt_out), 32'd1);
    tick();
    pkt_valid_in = 1'b1;
    tick();
    pkt_valid_in = 1'b0;
    check("wd_recover_scanning", 32'(scanning_out), 32'd1);
    check("wd_recover_retry", 32'(retry_cnt_out), 32'd0);

    // Shutdown from RUN: parser drops at once, stop command, then IDLE.
    scan_en_in = 1'b0;
    tick();
    check("sd_parser_en", 32'(parser_en_out), 32'd0);
    check("sd_scanning", 32'(scanning_out), 32'd0);
    uart_byte(8'hA5, "sd_hdr", w);
    check("sd_hdr_wait", 32'(w), 32'd0);
    uart_byte(8'h65, "sd_code", w);
    seen = 0;
    repeat (60) begin
      tick();
      if (tx_start_out === 1'b1) seen = 1;
    end
    check("sd_idle_quiet", 32'(seen), 32'd0);

    // Fault after three expiries with no packets.
    scan_en_in = 1'b1;
    full_seq("f1");
    wait_start(8'hA5, "f1_restart", w);
    check("f1_expiry_wait", 32'(w), 32'd200);
    check("f1_retry", 32'(retry_cnt_out), 32'd1);
    finish_byte(8'hA5, "f1_restart");
    uart_byte(8'h65, "f2_stop_code", w);
    uart_byte(8'hA5, "f2_start_hdr", w);
    check("f2_drain_gap", 32'(w), 32'd50);
    uart_byte(8'h60, "f2_start_code", w);
    wait_start(8'hA5, "f2_restart", w);
    check("f2_expiry_wait", 32'(w), 32'd200);
    check("f2_retry", 32'(retry_cnt_out), 32'd2);
    finish_byte(8'hA5, "f2_restart");
    uart_byte(8'h65, "f3_stop_code", w);
    uart_byte(8'hA5, "f3_start_hdr", w);
    uart_byte(8'h60, "f3_start_code", w);
    repeat (199) tick();
    check("f3_pre_fault", 32'(fault_out), 32'd0);
    tick();
    check("f3_fault", 32'(fault_out), 32'd1);
    check("f3_parser_en", 32'(parser_en_out), 32'd0);
    check("f3_retry", 32'(retry_cnt_out), 32'd2);
    seen = 0;
    repeat (300) begin
      if (tx_start_out === 1'b1) seen = 1;
      tick();
    end
    check("f3_no_tx", 32'(seen), 32'd0);
    check("f3_fault_held", 32'(fault_out), 32'd1);
    scan_en_in = 1'b0;
    tick();
    check("f3_exit_fault", 32'(fault_out), 32'd0);
    seen = 0;
    repeat (20) begin
      tick();
      if (tx_start_out === 1'b1) seen = 1;
    end
    check("f3_exit_no_tx", 32'(seen), 32'd0);

    // Shutdown while 0x60 is in flight: 0x60 completes, then the stop command only.
    scan_en_in = 1'b1;
    uart_byte(8'hA5, "mb_stop_hdr", w);
    uart_byte(8'h65, "mb_stop_code", w);
    uart_byte(8'hA5, "mb_start_hdr", w);
    wait_start(8'h60, "mb_start_code", w);
    tick();
    scan_en_in = 1'b0;
    repeat (7) tick();
    check("mb_held_60", 32'(tx_data_out), 32'h60);
    tx_done_in = 1'b1;
    tick();
    tx_done_in = 1'b0;
    uart_byte(8'hA5, "mb_sd_hdr", w);
    check("mb_sd_hdr_wait", 32'(w), 32'd0);
    uart_byte(8'h65, "mb_sd_code", w);
    check("mb_sd_code_wait", 32'(w), 32'd0);
    seen = 0;
    repeat (80) begin
      tick();
      if (tx_start_out === 1'b1) seen = 1;
    end
    check("mb_idle_quiet", 32'(seen), 32'd0);
    check("mb_parser_en", 32'(parser_en_out), 32'd0);

    // Asynchronous reset while the start header is in flight.
    scan_en_in = 1'b1;
    uart_byte(8'hA5, "ar_stop_hdr", w);
    uart_byte(8'h65, "ar_stop_code", w);
    wait_start(8'hA5, "ar_start_hdr", w);
    repeat (3) tick();
    #3 rst_n_in = 1'b0;
    #1;
    check("ar_tx_start", 32'(tx_start_out), 32'd0);
    check("ar_tx_data", 32'(tx_data_out), 32'd0);
    check("ar_parser_en", 32'(parser_en_out), 32'd0);
    check("ar_scanning", 32'(scanning_out), 32'd0);
    check("ar_fault", 32'(fault_out), 32'd0);
    check("ar_retry", 32'(retry_cnt_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    uart_byte(8'hA5, "ar_re_hdr", w);
    check("ar_re_hdr_wait", 32'(w), 32'd1);
    uart_byte(8'h65, "ar_re_code", w);
    check("ar_re_code_wait", 32'(w), 32'd0);

    scan_en_in = 1'b0;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
